// File: rtl/asym_fifoctl_pkg.sv
// ---------------------------------------------------------------------------
// asym_fifoctl_pkg
// Shared types and helpers for the asymmetric FIFO controller:
//   err_mode_e   - how the error output behaves (sticky / one-cycle pulse)
//   byte_order_e - where the first sub-word sits inside a RAM word
//   idx_width()  - clog2-based width of an index covering 0..n-1 (min 1 bit)
// ---------------------------------------------------------------------------
package asym_fifoctl_pkg;

  typedef enum logic {
    ERR_STICKY = 1'b0,
    ERR_PULSE  = 1'b1
  } err_mode_e;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } byte_order_e;

  // Width of an index spanning n positions; never narrower than one bit so
  // that degenerate counters (n = 1) still have a legal declaration.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/asym_fifoctl_ptr.sv
// ---------------------------------------------------------------------------
// asym_fifoctl_ptr
// Modulo-DEPTH address pointer. DEPTH need not be a power of two, so the
// wrap from DEPTH-1 back to 0 is explicit.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset (pointer -> 0)
//   inc   in   advance the pointer by one
//   ptr   out  current pointer value
// ---------------------------------------------------------------------------
module asym_fifoctl_ptr #(
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/asym_fifoctl_s1_dyn.sv
// ---------------------------------------------------------------------------
// asym_fifoctl_s1_dyn
// Single-clock FIFO controller for an external RAM with asymmetric write and
// read widths and runtime almost-empty / almost-full thresholds.
//   IN_W <  OUT_W : pack K input sub-words into one RAM word
//   IN_W >  OUT_W : unpack each RAM word into K output sub-words
//   IN_W == OUT_W : plain FIFO controller
// Parameters: IN_W, OUT_W, DEPTH (2..256), ERR_MODE (0 sticky, 1 pulse),
//             BYTE_ORDER (0 first sub-word in MSBs, 1 in LSBs).
// Ports (AW = clog2(DEPTH), RW = max(IN_W,OUT_W)):
//   clk, rst_n                     clock / asynchronous active-low reset
//   push_req_n, pop_req_n, flush_n active-low requests
//   ae_level, af_level   [AW:0]    almost-empty / almost-full thresholds
//   data_in              [IN_W]    write data
//   rd_data              [RW]      RAM read data (combinational from rd_addr)
//   we_n, wr_addr, rd_addr, wr_data RAM control
//   data_out             [OUT_W]   read data
//   empty, almost_empty, half_full, almost_full, full, ram_full  status
//   part_wd                        packing register partially filled
//   error                          overflow / underflow / flush error
//   word_count           [AW:0]    RAM words held
// Build option: define ASYM_FIFOCTL_WCOUNT_EN to drive word_count from the
// RAM word counter; otherwise word_count is tied to zero.
// ---------------------------------------------------------------------------
module asym_fifoctl_s1_dyn
  import asym_fifoctl_pkg::*;
#(
  parameter int  IN_W       = 8,
  parameter int  OUT_W      = 32,
  parameter int  DEPTH      = 12,
  parameter int  ERR_MODE   = 0,
  parameter int  BYTE_ORDER = 0,
  localparam int AW         = idx_width(DEPTH),
  localparam int RW         = (IN_W > OUT_W) ? IN_W : OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             flush_n,
  input  logic [AW:0]      ae_level,
  input  logic [AW:0]      af_level,
  input  logic [IN_W-1:0]  data_in,
  input  logic [RW-1:0]    rd_data,
  output logic             we_n,
  output logic [AW-1:0]    wr_addr,
  output logic [AW-1:0]    rd_addr,
  output logic [RW-1:0]    wr_data,
  output logic [OUT_W-1:0] data_out,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             ram_full,
  output logic             part_wd,
  output logic             error,
  output logic [AW:0]      word_count
);

  localparam int  NW        = (IN_W < OUT_W) ? IN_W : OUT_W;
  localparam int  K         = RW / NW;
  localparam int  KW        = idx_width(K);
  localparam int  CW        = AW + 1;
  localparam bit  PACK      = (IN_W < OUT_W);
  localparam bit  UNPACK    = (IN_W > OUT_W);
  localparam bit  LSB_FIRST = (BYTE_ORDER == int'(ORDER_LSB_FIRST));
  localparam bit  PULSE_ERR = (ERR_MODE == int'(ERR_PULSE));
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_C  = CW'((DEPTH + 1) / 2);

  // Bit position of sub-word i (width w) inside a RW-wide RAM word.
  function automatic int slot_lsb(input int i, input int w);
    return LSB_FIRST ? (i * w) : (RW - (i + 1) * w);
  endfunction

  // Request decode and shared handshake terms
  logic          push, pop, flush;
  logic          not_empty, ram_full_now;
  logic          pop_ok, pop_retire;
  logic          wr_req, write_ok, ram_wr, wr_rej, underflow, err_event;
  logic [RW-1:0] wr_word;

  // Registered state
  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, almost_empty_reg, half_full_reg;
  logic          almost_full_reg, ram_full_reg, error_reg;

  assign push         = ~push_req_n;
  assign pop          = ~pop_req_n;
  assign flush        = ~flush_n;
  assign not_empty    = (count_reg != '0);
  assign ram_full_now = (count_reg == DEPTH_C);
  assign pop_ok       = pop & not_empty;
  assign underflow    = pop & ~not_empty;

  // A RAM write is possible when there is room, or when a pop retires a word
  // in the same cycle and so frees the slot being written.
  assign write_ok  = ~ram_full_now | pop_retire;
  assign ram_wr    = wr_req & write_ok;
  assign wr_rej    = wr_req & ~write_ok;
  assign err_event = wr_rej | underflow;

  // Gate the write strobe with rst_n so a request held during reset can
  // never reach the RAM.
  assign we_n    = ~(ram_wr & rst_n);
  assign wr_data = wr_word;

  // -------------------------------------------------------------------------
  // Write side
  // -------------------------------------------------------------------------
  generate
    if (PACK) begin : g_pack
      logic [KW-1:0] pack_cnt_reg, pack_cnt_next;
      logic [RW-1:0] pack_reg, pack_next, merged;
      logic          pack_last, part;

      assign pack_last = (pack_cnt_reg == KW'(K - 1));
      assign part      = (pack_cnt_reg != '0);

      // Packing register with the incoming sub-word dropped into its slot.
      always_comb begin
        merged = pack_reg;
        for (int i = 0; i < K; i++) begin
          if (pack_cnt_reg == KW'(i)) begin
            merged[slot_lsb(i, IN_W) +: IN_W] = data_in;
          end
        end
      end

      // The K-th push or a flush writes; a flush alongside a push carries the
      // new sub-word. A flush with nothing packed and no push is a no-op.
      assign wr_req  = (push & pack_last) | (flush & (part | push));
      assign wr_word = push ? merged : pack_reg;

      always_comb begin
        pack_cnt_next = pack_cnt_reg;
        pack_next     = pack_reg;
        if (ram_wr) begin
          // Cleared so that unfilled slots of the next partial word are zero.
          pack_cnt_next = '0;
          pack_next     = '0;
        end else if (push & ~wr_rej) begin
          pack_cnt_next = pack_cnt_reg + KW'(1);
          pack_next     = merged;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pack_cnt_reg <= '0;
          pack_reg     <= '0;
        end else begin
          pack_cnt_reg <= pack_cnt_next;
          pack_reg     <= pack_next;
        end
      end

      assign part_wd = part;
      assign full    = ram_full_reg & pack_last;
    end else begin : g_direct
      logic unused_flush;

      // Every push is a whole RAM word; nothing is ever partially packed.
      assign wr_req       = push;
      assign wr_word      = data_in;
      assign part_wd      = 1'b0;
      assign full         = ram_full_reg;
      assign unused_flush = flush;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read side
  // -------------------------------------------------------------------------
  generate
    if (UNPACK) begin : g_unpack
      logic [KW-1:0] rd_sub_reg;
      logic          sub_last;

      assign sub_last   = (rd_sub_reg == KW'(K - 1));
      // Only the last sub-word of a RAM word retires it.
      assign pop_retire = pop_ok & sub_last;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_sub_reg <= '0;
        end else if (pop_ok) begin
          rd_sub_reg <= sub_last ? '0 : rd_sub_reg + KW'(1);
        end
      end

      always_comb begin
        data_out = '0;
        for (int i = 0; i < K; i++) begin
          if (rd_sub_reg == KW'(i)) begin
            data_out = rd_data[slot_lsb(i, OUT_W) +: OUT_W];
          end
        end
      end
    end else begin : g_whole
      assign pop_retire = pop_ok;
      assign data_out   = rd_data;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Pointers
  // -------------------------------------------------------------------------
  asym_fifoctl_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ram_wr),
    .ptr   (wr_addr)
  );

  asym_fifoctl_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_retire),
    .ptr   (rd_addr)
  );

  // -------------------------------------------------------------------------
  // RAM word count, status flags, error
  // -------------------------------------------------------------------------
  always_comb begin
    count_next = count_reg;
    if (ram_wr & ~pop_retire) begin
      count_next = count_reg + CW'(1);
    end else if (~ram_wr & pop_retire) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Flags are registered from the next count so that threshold inputs are
  // sampled at the edge, like every other input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
      half_full_reg    <= 1'b0;
      almost_full_reg  <= 1'b0;
      ram_full_reg     <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      almost_empty_reg <= (count_next <= ae_level);
      half_full_reg    <= (count_next >= HALF_C);
      // count >= DEPTH - af_level, rearranged to avoid a negative difference
      almost_full_reg  <= ({1'b0, count_next} + {1'b0, af_level}) >= {1'b0, DEPTH_C};
      ram_full_reg     <= (count_next == DEPTH_C);
      error_reg        <= PULSE_ERR ? err_event : (error_reg | err_event);
    end
  end

  assign empty        = empty_reg;
  assign almost_empty = almost_empty_reg;
  assign half_full    = half_full_reg;
  assign almost_full  = almost_full_reg;
  assign ram_full     = ram_full_reg;
  assign error        = error_reg;

`ifdef ASYM_FIFOCTL_WCOUNT_EN
  assign word_count = count_reg;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_asym_fifoctl_s1_dyn.sv
// ---------------------------------------------------------------------------
// tb_asym_fifoctl_s1_dyn
// Directed bench for two controller instances sharing one clock:
//   p_* : pack   IN_W=8,  OUT_W=32, DEPTH=12, sticky error, MSB-first
//   u_* : unpack IN_W=32, OUT_W=8,  DEPTH=12, pulse error,  LSB-first
// Each instance drives a small behavioural RAM with combinational read.
// ---------------------------------------------------------------------------
module tb_asym_fifoctl_s1_dyn;

  logic clk;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- pack instance ----------------
  logic        p_rst_n, p_push_n, p_pop_n, p_flush_n;
  logic [4:0]  p_ae, p_af, p_wc;
  logic [7:0]  p_din;
  logic [31:0] p_rd_data, p_wr_data, p_dout;
  logic        p_we_n;
  logic [3:0]  p_wr_addr, p_rd_addr;
  logic        p_empty, p_aempty, p_hf, p_afull, p_full, p_rfull, p_part, p_err;
  logic [31:0] p_mem [12];

  asym_fifoctl_s1_dyn #(
    .IN_W(8), .OUT_W(32), .DEPTH(12), .ERR_MODE(0), .BYTE_ORDER(0)
  ) u_dut_pack (
    .clk(clk), .rst_n(p_rst_n), .push_req_n(p_push_n), .pop_req_n(p_pop_n),
    .flush_n(p_flush_n), .ae_level(p_ae), .af_level(p_af), .data_in(p_din),
    .rd_data(p_rd_data), .we_n(p_we_n), .wr_addr(p_wr_addr), .rd_addr(p_rd_addr),
    .wr_data(p_wr_data), .data_out(p_dout), .empty(p_empty),
    .almost_empty(p_aempty), .half_full(p_hf), .almost_full(p_afull),
    .full(p_full), .ram_full(p_rfull), .part_wd(p_part), .error(p_err),
    .word_count(p_wc)
  );

  assign p_rd_data = p_mem[p_rd_addr];
  always @(posedge clk) if (!p_we_n) p_mem[p_wr_addr] <= p_wr_data;

  // ---------------- unpack instance ----------------
  logic        u_rst_n, u_push_n, u_pop_n, u_flush_n;
  logic [4:0]  u_ae, u_af, u_wc;
  logic [31:0] u_din, u_rd_data, u_wr_data;
  logic [7:0]  u_dout;
  logic        u_we_n;
  logic [3:0]  u_wr_addr, u_rd_addr;
  logic        u_empty, u_aempty, u_hf, u_afull, u_full, u_rfull, u_part, u_err;
  logic [31:0] u_mem [12];

  asym_fifoctl_s1_dyn #(
    .IN_W(32), .OUT_W(8), .DEPTH(12), .ERR_MODE(1), .BYTE_ORDER(1)
  ) u_dut_unpack (
    .clk(clk), .rst_n(u_rst_n), .push_req_n(u_push_n), .pop_req_n(u_pop_n),
    .flush_n(u_flush_n), .ae_level(u_ae), .af_level(u_af), .data_in(u_din),
    .rd_data(u_rd_data), .we_n(u_we_n), .wr_addr(u_wr_addr), .rd_addr(u_rd_addr),
    .wr_data(u_wr_data), .data_out(u_dout), .empty(u_empty),
    .almost_empty(u_aempty), .half_full(u_hf), .almost_full(u_afull),
    .full(u_full), .ram_full(u_rfull), .part_wd(u_part), .error(u_err),
    .word_count(u_wc)
  );

  assign u_rd_data = u_mem[u_rd_addr];
  always @(posedge clk) if (!u_we_n) u_mem[u_wr_addr] <= u_wr_data;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] exp_wc(input int c);
`ifdef ASYM_FIFOCTL_WCOUNT_EN
    return 32'(c);
`else
    return (c == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic p_set(input logic push, input logic pop, input logic flush,
                       input logic [7:0] d);
    p_push_n  = ~push;
    p_pop_n   = ~pop;
    p_flush_n = ~flush;
    p_din     = d;
  endtask

  // Advance one clock, then return requests to idle away from the edge.
  task automatic tick;
    @(posedge clk);
    #1;
    p_push_n = 1'b1; p_pop_n = 1'b1; p_flush_n = 1'b1;
    u_push_n = 1'b1; u_pop_n = 1'b1; u_flush_n = 1'b1;
  endtask

  logic [7:0] exp_b [4];

  initial begin
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    p_rst_n = 1'b0; p_push_n = 1'b1; p_pop_n = 1'b1; p_flush_n = 1'b1;
    p_ae = 5'd2; p_af = 5'd2; p_din = '0;
    u_rst_n = 1'b0; u_push_n = 1'b1; u_pop_n = 1'b1; u_flush_n = 1'b1;
    u_ae = 5'd1; u_af = 5'd1; u_din = '0;
    #12;

    // ---- reset values ----
    check("rst_empty",    32'(p_empty),   32'd1);
    check("rst_aempty",   32'(p_aempty),  32'd1);
    check("rst_full",     32'(p_full),    32'd0);
    check("rst_ram_full", 32'(p_rfull),   32'd0);
    check("rst_half",     32'(p_hf),      32'd0);
    check("rst_afull",    32'(p_afull),   32'd0);
    check("rst_we_n",     32'(p_we_n),    32'd1);
    check("rst_wr_addr",  32'(p_wr_addr), 32'd0);
    check("rst_rd_addr",  32'(p_rd_addr), 32'd0);
    check("rst_part_wd",  32'(p_part),    32'd0);
    check("rst_error",    32'(p_err),     32'd0);
    check("rst_wcount",   32'(p_wc),      exp_wc(0));
    check("rst_u_empty",  32'(u_empty),   32'd1);
    p_rst_n = 1'b1; u_rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- unpack: underflow pulse ----
    u_pop_n = 1'b0;
    tick;
    check("u_underflow_err",   32'(u_err),     32'd1);
    check("u_underflow_rdptr", 32'(u_rd_addr), 32'd0);
    check("u_underflow_empty", 32'(u_empty),   32'd1);
    tick;
    check("u_err_pulse_clear", 32'(u_err),     32'd0);

    // ---- unpack: write one word, read four sub-words LSB first ----
    u_din = 32'h4433_2211; u_push_n = 1'b0;
    #1;
    check("u_push_we_n",  32'(u_we_n),    32'd0);
    check("u_push_wdata", u_wr_data,      32'h4433_2211);
    tick;
    check("u_push_empty", 32'(u_empty),   32'd0);
    check("u_push_wraddr", 32'(u_wr_addr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      u_pop_n = 1'b0;
      #1;
      check($sformatf("u_pop%0d_dout", i), 32'(u_dout), 32'(exp_b[i]));
      tick;
      check($sformatf("u_pop%0d_rdaddr", i), 32'(u_rd_addr), (i < 3) ? 32'd0 : 32'd1);
    end
    check("u_drain_empty", 32'(u_empty), 32'd1);
    check("u_drain_error", 32'(u_err),   32'd0);

    // ---- pack: four pushes assemble one word ----
    p_set(1, 0, 0, 8'h11); tick;
    check("p_part_after1", 32'(p_part),  32'd1);
    check("p_we_n_after1", 32'(p_we_n),  32'd1);
    p_set(1, 0, 0, 8'h22); tick;
    p_set(1, 0, 0, 8'h33); tick;
    p_set(1, 0, 0, 8'h44);
    #1;
    check("p_push4_we_n",  32'(p_we_n),  32'd0);
    check("p_push4_wdata", p_wr_data,    32'h1122_3344);
    check("p_push4_empty_before", 32'(p_empty), 32'd1);
    tick;
    check("p_push4_empty", 32'(p_empty), 32'd0);
    check("p_push4_part",  32'(p_part),  32'd0);
    check("p_push4_wraddr", 32'(p_wr_addr), 32'd1);
    check("p_push4_aempty", 32'(p_aempty), 32'd1);

    // ---- runtime almost-empty threshold ----
    p_ae = 5'd0; tick;
    check("p_ae0_aempty", 32'(p_aempty), 32'd0);
    p_ae = 5'd2; tick;
    check("p_ae2_aempty", 32'(p_aempty), 32'd1);

    // ---- pack: flush a partial word ----
    p_set(1, 0, 0, 8'hAA); tick;
    p_set(1, 0, 0, 8'hBB); tick;
    check("p_flush_part_before", 32'(p_part), 32'd1);
    p_set(0, 0, 1, 8'h00);
    #1;
    check("p_flush_we_n",  32'(p_we_n), 32'd0);
    check("p_flush_wdata", p_wr_data,   32'hAABB_0000);
    tick;
    check("p_flush_part_after", 32'(p_part), 32'd0);
    check("p_flush_wraddr", 32'(p_wr_addr), 32'd2);

    // flush with nothing packed: no write
    p_set(0, 0, 1, 8'h00);
    #1;
    check("p_flush_idle_we_n", 32'(p_we_n), 32'd1);
    tick;

    // ---- pack: pop whole word ----
    p_set(0, 1, 0, 8'h00);
    #1;
    check("p_pop_dout", p_dout, 32'h1122_3344);
    tick;
    check("p_pop_rdaddr", 32'(p_rd_addr), 32'd1);

    // ---- pack: push together with flush ----
    p_set(1, 0, 0, 8'h55); tick;
    p_set(1, 0, 1, 8'h66);
    #1;
    check("p_pushflush_wdata", p_wr_data, 32'h5566_0000);
    tick;
    check("p_pushflush_part", 32'(p_part), 32'd0);
    p_set(1, 0, 0, 8'h77); tick;
    check("p_fresh_part", 32'(p_part), 32'd1);
    p_set(0, 0, 1, 8'h00);
    #1;
    check("p_fresh_wdata", p_wr_data, 32'h7700_0000);
    tick;

    // ---- pack: fill to DEPTH words (3 held, 9 more) ----
    for (int w = 0; w < 9; w++) begin
      for (int b = 0; b < 4; b++) begin
        p_set(1, 0, 0, 8'(w * 4 + b));
        tick;
      end
      check($sformatf("p_fill%0d_half", w),  32'(p_hf),    (w + 4 >= 6)  ? 32'd1 : 32'd0);
      check($sformatf("p_fill%0d_afull", w), 32'(p_afull), (w + 4 >= 10) ? 32'd1 : 32'd0);
    end
    check("p_fill_ram_full", 32'(p_rfull),   32'd1);
    check("p_fill_full",     32'(p_full),    32'd0);
    check("p_fill_aempty",   32'(p_aempty),  32'd0);
    check("p_fill_wraddr",   32'(p_wr_addr), 32'd1);
    check("p_fill_wcount",   32'(p_wc),      exp_wc(12));
    check("p_fill_error",    32'(p_err),     32'd0);

    // ---- pack: push + retiring pop while full ----
    p_set(1, 0, 0, 8'hC0); tick;
    p_set(1, 0, 0, 8'hC1); tick;
    p_set(1, 0, 0, 8'hC2); tick;
    check("p_full_flag", 32'(p_full), 32'd1);
    check("p_full_err",  32'(p_err),  32'd0);
    p_set(1, 1, 0, 8'hC3);
    #1;
    check("p_pp_we_n",  32'(p_we_n),  32'd0);
    check("p_pp_wdata", p_wr_data,    32'hC0C1_C2C3);
    check("p_pp_dout",  p_dout,       32'hAABB_0000);
    tick;
    check("p_pp_ram_full", 32'(p_rfull),   32'd1);
    check("p_pp_error",    32'(p_err),     32'd0);
    check("p_pp_rdaddr",   32'(p_rd_addr), 32'd2);
    check("p_pp_wraddr",   32'(p_wr_addr), 32'd2);

    // ---- pack: overflow, sticky error ----
    p_set(1, 0, 0, 8'hD0); tick;
    p_set(1, 0, 0, 8'hD1); tick;
    p_set(1, 0, 0, 8'hD2); tick;
    p_set(1, 0, 0, 8'hD3);
    #1;
    check("p_ovf_we_n", 32'(p_we_n), 32'd1);
    tick;
    check("p_ovf_error",  32'(p_err),     32'd1);
    check("p_ovf_wraddr", 32'(p_wr_addr), 32'd2);
    check("p_ovf_part",   32'(p_part),    32'd1);
    tick; tick; tick;
    check("p_err_sticky", 32'(p_err), 32'd1);

    // ---- pack: reset mid-pack ----
    p_set(1, 0, 0, 8'hEE);
    p_rst_n = 1'b0;
    #1;
    check("p_mrst_we_n",   32'(p_we_n),    32'd1);
    check("p_mrst_part",   32'(p_part),    32'd0);
    check("p_mrst_error",  32'(p_err),     32'd0);
    check("p_mrst_empty",  32'(p_empty),   32'd1);
    check("p_mrst_aempty", 32'(p_aempty),  32'd1);
    check("p_mrst_rfull",  32'(p_rfull),   32'd0);
    check("p_mrst_full",   32'(p_full),    32'd0);
    check("p_mrst_wraddr", 32'(p_wr_addr), 32'd0);
    check("p_mrst_rdaddr", 32'(p_rd_addr), 32'd0);
    check("p_mrst_wcount", 32'(p_wc),      exp_wc(0));
    @(posedge clk); #1;
    check("p_mrst_edge_we_n", 32'(p_we_n), 32'd1);
    check("p_mrst_ram0",      p_mem[0],    32'h2021_2223);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
